// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose:
//   Shares the multiplexed 8-bit memory bus between two processor-side
//   requesters using round-robin arbitration. It also sequences the winning
//   transaction on the bus in this order: upper address, optional idle gap,
//   lower address, then either the write data or a bounded wait for read data.
//   When the transaction ends, the owner receives a one-cycle done pulse.
//   Reads to pages where no memory answers end on a timeout.
//
// Ports:
//   b_Clock      system clock; all state changes on the rising edge
//   b_Reset_L    asynchronous active-low reset
//   req          per-requester request level, held until its done pulse
//   req_rw       per-requester direction (1 = read, 0 = write)
//   req_addr     per-requester 16-bit address
//   req_wdata    per-requester write data
//   req_gap      per-requester idle cycles between the two address phases
//   grant        one-hot owner of the bus from acceptance through DONE
//   done         one-cycle completion pulse to the owner
//   rdata        last read data; valid alongside done for a read
//   timed_out    set with done when a read received no data
//   b_ad_out     address/data value driven onto the bus
//   b_ad_oe      bus output enable
//   b_ad_in      value sampled from the bus (read data)
//   b_aValid_L   low during the upper and lower address phases
//   b_rw         transaction direction, valid from the upper address phase on
//   b_dValid_L   memory strobe, low for one cycle when b_ad_in holds read data
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 20,
  parameter int GAP_W   = 5
) (
  input  logic                       b_Clock,
  input  logic                       b_Reset_L,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_rw,
  input  logic [NREQ-1:0][15:0]      req_addr,
  input  logic [NREQ-1:0][7:0]       req_wdata,
  input  logic [NREQ-1:0][GAP_W-1:0] req_gap,
  output logic [NREQ-1:0]            grant,
  output logic [NREQ-1:0]            done,
  output logic [7:0]                 rdata,
  output logic                       timed_out,
  output logic [7:0]                 b_ad_out,
  output logic                       b_ad_oe,
  input  logic [7:0]                 b_ad_in,
  output logic                       b_aValid_L,
  output logic                       b_rw,
  input  logic                       b_dValid_L
);

  // One counter serves two purposes: it counts gap cycles and it counts
  // read-wait cycles. It must therefore be wide enough for both
  // 2**GAP_W - 1 and TIMEOUT - 1.
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CNT_W = (TO_W > GAP_W) ? TO_W : GAP_W;

  typedef enum logic [2:0] {
    IDLE,
    AH,
    GAP,
    AL,
    WDATA,
    RWAIT,
    DONE
  } state_t;

  state_t            state_reg,     state_next;
  logic              owner_reg,     owner_next;
  logic              last_reg,      last_next;
  logic [15:0]       addr_reg,      addr_next;
  logic              rw_reg,        rw_next;
  logic [7:0]        wdata_reg,     wdata_next;
  logic [GAP_W-1:0]  gap_reg,       gap_next;
  logic [CNT_W-1:0]  cnt_reg,       cnt_next;
  logic [7:0]        rdata_reg,     rdata_next;
  logic              timed_out_reg, timed_out_next;

  logic              winner;
  logic              busy;

  // ---------------------------------------------------------------------------
  // Round-robin choice. last_reg holds the most recent owner. When both
  // requesters are active, the other one wins. Otherwise the single active
  // requester wins. last_reg resets to 1, so requester 0 wins first.
  // ---------------------------------------------------------------------------
  always_comb begin
    winner = 1'b0;
    if (req[0] && req[1]) begin
      winner = ~last_reg;
    end else begin
      winner = req[1];
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge b_Clock or negedge b_Reset_L) begin
    if (!b_Reset_L) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b0;
      last_reg      <= 1'b1;
      addr_reg      <= '0;
      rw_reg        <= 1'b0;
      wdata_reg     <= '0;
      gap_reg       <= '0;
      cnt_reg       <= '0;
      rdata_reg     <= '0;
      timed_out_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      last_reg      <= last_next;
      addr_reg      <= addr_next;
      rw_reg        <= rw_next;
      wdata_reg     <= wdata_next;
      gap_reg       <= gap_next;
      cnt_reg       <= cnt_next;
      rdata_reg     <= rdata_next;
      timed_out_reg <= timed_out_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    last_next      = last_reg;
    addr_next      = addr_reg;
    rw_next        = rw_reg;
    wdata_next     = wdata_reg;
    gap_next       = gap_reg;
    cnt_next       = cnt_reg;
    rdata_next     = rdata_reg;
    timed_out_next = timed_out_reg;

    case (state_reg)
      IDLE: begin
        // Copy the winner's request into local registers. After this
        // point, changes on the request inputs cannot affect the
        // transaction in progress.
        if (|req) begin
          owner_next = winner;
          addr_next  = req_addr[winner];
          rw_next    = req_rw[winner];
          wdata_next = req_wdata[winner];
          gap_next   = req_gap[winner];
          state_next = AH;
        end
      end

      AH: begin
        if (gap_reg != '0) begin
          cnt_next   = CNT_W'(1);
          state_next = GAP;
        end else begin
          state_next = AL;
        end
      end

      GAP: begin
        // cnt_reg is the number of the current gap cycle, starting at 1.
        if (cnt_reg == CNT_W'(gap_reg)) begin
          state_next = AL;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      AL: begin
        cnt_next   = '0;
        state_next = rw_reg ? RWAIT : WDATA;
      end

      WDATA: begin
        // A write never times out. Clearing the flag here means it does
        // not carry over from an earlier aborted read.
        timed_out_next = 1'b0;
        state_next     = DONE;
      end

      RWAIT: begin
        // Data is checked before the limit. If the strobe arrives on the
        // last allowed cycle, the read still completes normally.
        if (!b_dValid_L) begin
          rdata_next     = b_ad_in;
          timed_out_next = 1'b0;
          state_next     = DONE;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          timed_out_next = 1'b1;
          state_next     = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      DONE: begin
        last_next  = owner_reg;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus outputs. These decode the registered state only, so they change on
  // clock edges and on reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    b_ad_out   = '0;
    b_ad_oe    = 1'b0;
    b_aValid_L = 1'b1;
    b_rw       = 1'b0;

    case (state_reg)
      AH: begin
        b_aValid_L = 1'b0;
        b_ad_oe    = 1'b1;
        b_ad_out   = addr_reg[15:8];
        b_rw       = rw_reg;
      end
      GAP: begin
        b_rw = rw_reg;
      end
      AL: begin
        b_aValid_L = 1'b0;
        b_ad_oe    = 1'b1;
        b_ad_out   = addr_reg[7:0];
        b_rw       = rw_reg;
      end
      WDATA: begin
        b_ad_oe  = 1'b1;
        b_ad_out = wdata_reg;
        b_rw     = rw_reg;
      end
      RWAIT: begin
        b_rw = rw_reg;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Requester-side outputs. Grant covers every cycle from acceptance through
  // DONE. The done pulse is the DONE state steered to the owner's bit.
  // ---------------------------------------------------------------------------
  assign busy = (state_reg != IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_owner
      assign grant[gi] = busy && (owner_reg == 1'(gi));
      assign done[gi]  = (state_reg == DONE) && (owner_reg == 1'(gi));
    end
  endgenerate

  assign rdata     = rdata_reg;
  assign timed_out = timed_out_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Purpose:
//   Self-checking bench for mem_bus_arbiter. A behavioural memory on the bus
//   side answers reads after a programmed delay. Pages with addr[15:14] == 0
//   never answer. Each transaction's expectations come from one of two
//   sources: a fixed table, or a transaction-level model covering memory
//   contents, latency and round-robin order.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  localparam int TIMEOUT = 20;
  localparam int GAP_W   = 5;

  logic                  b_Clock   = 1'b0;
  logic                  b_Reset_L = 1'b0;
  logic [1:0]            req       = '0;
  logic [1:0]            req_rw    = '0;
  logic [1:0][15:0]      req_addr  = '0;
  logic [1:0][7:0]       req_wdata = '0;
  logic [1:0][GAP_W-1:0] req_gap   = '0;
  logic [1:0]            grant;
  logic [1:0]            done;
  logic [7:0]            rdata;
  logic                  timed_out;
  logic [7:0]            b_ad_out;
  logic                  b_ad_oe;
  logic [7:0]            b_ad_in    = '0;
  logic                  b_aValid_L;
  logic                  b_rw;
  logic                  b_dValid_L = 1'b1;

  mem_bus_arbiter #(.NREQ(2), .TIMEOUT(TIMEOUT), .GAP_W(GAP_W)) dut (
    .b_Clock    (b_Clock),
    .b_Reset_L  (b_Reset_L),
    .req        (req),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_gap    (req_gap),
    .grant      (grant),
    .done       (done),
    .rdata      (rdata),
    .timed_out  (timed_out),
    .b_ad_out   (b_ad_out),
    .b_ad_oe    (b_ad_oe),
    .b_ad_in    (b_ad_in),
    .b_aValid_L (b_aValid_L),
    .b_rw       (b_rw),
    .b_dValid_L (b_dValid_L)
  );

  always #5 b_Clock = ~b_Clock;

  typedef struct {
    int          c;
    bit          rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          gap;
    int          delay;      // read strobe on this RWAIT cycle; 0 = never
    logic [7:0]  exp_rdata;
    bit          exp_to;
    int          lat;
  } txn_t;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- memory contents shared by model and bus memory ----------
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // ---------------- bus-side memory responder ----------------
  logic [7:0]  bus_mem [logic [15:0]];
  int          resp_delay [2];
  int          rsp_phase = 0;
  int          rsp_j     = 0;
  bit          rsp_read  = 0;
  int          rsp_dly   = 0;
  logic [15:0] rsp_addr  = '0;

  always @(negedge b_Clock) begin
    b_dValid_L = 1'b1;
    b_ad_in    = 8'($urandom);
    if (!b_Reset_L) begin
      rsp_phase = 0;
    end else if (!b_aValid_L) begin
      if (rsp_phase == 1) begin
        rsp_addr[7:0] = b_ad_out;
        rsp_phase     = 2;
        rsp_j         = 0;
        rsp_read      = b_rw;
        rsp_dly       = resp_delay[grant[1] ? 1 : 0];
      end else begin
        rsp_addr[15:8] = b_ad_out;
        rsp_phase      = 1;
      end
    end else if (rsp_phase == 2) begin
      rsp_j++;
      if (!rsp_read && rsp_j == 1 && b_ad_oe) bus_mem[rsp_addr] = b_ad_out;
      if (rsp_read && rsp_j == rsp_dly && rsp_addr[15:14] != 2'b00) begin
        b_dValid_L = 1'b0;
        b_ad_in    = bus_mem.exists(rsp_addr) ? bus_mem[rsp_addr] : init_val(rsp_addr);
      end
      if (rsp_j > 40) rsp_phase = 0;
    end
  end

  // ---------------- transaction-level reference model ----------------
  logic [7:0] m_mem [logic [15:0]];
  logic [7:0] m_rdata = 8'h00;
  int         m_last  = 1;

  task automatic model_fill(inout txn_t t);
    bit resp;
    int n;
    resp = (t.addr[15:14] != 2'b00) && (t.delay >= 1) && (t.delay <= TIMEOUT);
    if (!t.rw) begin
      m_mem[t.addr] = t.wdata;
      t.lat    = 5 + t.gap;
      t.exp_to = 1'b0;
    end else begin
      n        = resp ? t.delay : TIMEOUT;
      t.lat    = 4 + t.gap + n;
      t.exp_to = !resp;
      if (resp) m_rdata = m_mem.exists(t.addr) ? m_mem[t.addr] : init_val(t.addr);
    end
    t.exp_rdata = m_rdata;
    m_last      = t.c;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},     32'(grant),      32'h0);
    check({tag, "_done"},      32'(done),       32'h0);
    check({tag, "_rdata"},     32'(rdata),      32'h0);
    check({tag, "_timed_out"}, 32'(timed_out),  32'h0);
    check({tag, "_ad_oe"},     32'(b_ad_oe),    32'h0);
    check({tag, "_ad_out"},    32'(b_ad_out),   32'h0);
    check({tag, "_aValid_L"},  32'(b_aValid_L), 32'h1);
    check({tag, "_rw"},        32'(b_rw),       32'h0);
  endtask

  task automatic launch(input txn_t t);
    req_rw[t.c]    = t.rw;
    req_addr[t.c]  = t.addr;
    req_wdata[t.c] = t.wdata;
    req_gap[t.c]   = GAP_W'(t.gap);
    resp_delay[t.c] = t.delay;
    req[t.c]       = 1'b1;
  endtask

  // Monitors one transaction from its IDLE cycle (cycle 1) to its done pulse.
  // Checks bus phases, ownership, latency and results.
  task automatic wait_done(input int c, input txn_t t, input bit keep, input bit mess);
    int         cyc = 0;
    bit         got = 0;
    int         avl_n = 0;
    int         lo_cyc = -100;
    int         gapc = 0;
    logic [7:0] hi = 0, lo = 0, wd = 0;
    bit         wd_oe = 0, bad_grant = 0, bad_oe = 0, bad_rw = 0;
    logic [1:0] exp_g = 2'b01 << c;
    logic [1:0] done_seen = 0;
    while (!got && cyc < 100) begin
      @(negedge b_Clock);
      cyc++;
      if (cyc == 1) begin
        if (grant !== 2'b00) bad_grant = 1;
      end else if (grant !== exp_g) begin
        bad_grant = 1;
      end
      if (!b_aValid_L) begin
        if (b_ad_oe !== 1'b1) bad_oe = 1;
        if (b_rw !== t.rw) bad_rw = 1;
        if (avl_n == 0) hi = b_ad_out;
        else begin
          lo = b_ad_out;
          lo_cyc = cyc;
        end
        avl_n++;
      end else if (avl_n == 1) begin
        gapc++;
        if (b_ad_oe !== 1'b0) bad_oe = 1;
      end else if (avl_n == 2 && cyc == lo_cyc + 1 && !t.rw) begin
        wd    = b_ad_out;
        wd_oe = b_ad_oe;
      end else if (avl_n == 2 && t.rw && done === 2'b00 && b_ad_oe !== 1'b0) begin
        bad_oe = 1;
      end
      if (mess && cyc == 2) begin
        req_addr[c]  = 16'($urandom);
        req_wdata[c] = 8'($urandom);
        req_rw[c]    = ~req_rw[c];
        req_gap[c]   = GAP_W'($urandom);
        req[c]       = 1'b0;
      end
      if (done !== 2'b00) begin
        got       = 1;
        done_seen = done;
      end
    end
    if (!keep) req[c] = 1'b0;
    $display("txn c=%0d %s addr=%h gap=%0d dly=%0d lat=%0d rdata=%h to=%0b",
             c, t.rw ? "RD" : "WR", t.addr, t.gap, t.delay, cyc, rdata, timed_out);
    check("done_seen",   32'(got),       32'h1);
    check("done_bit",    32'(done_seen), 32'(exp_g));
    check("latency",     32'(cyc),       32'(t.lat));
    check("grant",       32'(bad_grant), 32'h0);
    check("addr_phases", 32'(avl_n),     32'h2);
    check("bus_hi",      32'(hi),        32'(t.addr[15:8]));
    check("bus_lo",      32'(lo),        32'(t.addr[7:0]));
    check("gap_cycles",  32'(gapc),      32'(t.gap));
    check("bus_oe",      32'(bad_oe),    32'h0);
    check("bus_rw",      32'(bad_rw),    32'h0);
    if (!t.rw) begin
      check("bus_wdata",    32'(wd),    32'(t.wdata));
      check("bus_wdata_oe", 32'(wd_oe), 32'h1);
    end
    check("rdata",     32'(rdata),     32'(t.exp_rdata));
    check("timed_out", 32'(timed_out), 32'(t.exp_to));
  endtask

  task automatic rand_txn(input int c, output txn_t t);
    t.c  = c;
    t.rw = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0: t.addr = 16'h7F11;
      1: t.addr = 16'hBF11;
      2: t.addr = 16'h3F11;
      3: t.addr = 16'h4043;
      4: t.addr = 16'hC5A0;
      default: t.addr = 16'h8000;
    endcase
    t.wdata     = 8'($urandom);
    t.gap       = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 31));
    t.delay     = int'($urandom_range(0, 22));
    t.exp_rdata = 8'h00;
    t.exp_to    = 1'b0;
    t.lat       = 0;
  endtask

  // ---------------- directed table ----------------
  txn_t tbl [11];

  initial begin
    txn_t t, t0, t1, tw, tl, tmp;
    int   w;
    bit   bad;

    tbl[0]  = '{0, 1'b0, 16'h7F11, 8'hAB, 0,  0,  8'h00, 1'b0, 5};
    tbl[1]  = '{0, 1'b1, 16'h7F11, 8'h00, 0,  3,  8'hAB, 1'b0, 7};
    tbl[2]  = '{1, 1'b0, 16'hBF11, 8'hCD, 0,  0,  8'hAB, 1'b0, 5};
    tbl[3]  = '{1, 1'b1, 16'hBF11, 8'h00, 20, 2,  8'hCD, 1'b0, 26};
    tbl[4]  = '{0, 1'b1, 16'h3F11, 8'h00, 0,  5,  8'hCD, 1'b1, 24};
    tbl[5]  = '{1, 1'b1, 16'h7F11, 8'h00, 0,  1,  8'hAB, 1'b0, 5};
    tbl[6]  = '{0, 1'b0, 16'h4043, 8'h43, 31, 0,  8'hAB, 1'b0, 36};
    tbl[7]  = '{0, 1'b1, 16'h4043, 8'h00, 0,  20, 8'h43, 1'b0, 24};
    tbl[8]  = '{1, 1'b1, 16'h4043, 8'h00, 0,  21, 8'h43, 1'b1, 24};
    tbl[9]  = '{1, 1'b0, 16'h8000, 8'h00, 1,  0,  8'h43, 1'b0, 6};
    tbl[10] = '{0, 1'b1, 16'h8000, 8'h00, 1,  1,  8'h00, 1'b0, 6};
    resp_delay[0] = 0;
    resp_delay[1] = 0;

    // Reset state
    repeat (3) @(negedge b_Clock);
    check_reset_outputs("reset");
    #2 b_Reset_L = 1'b1;

    // Contention from reset: both requesters hold req; order must be 0,1,0
    t0 = '{0, 1'b0, 16'hC000, 8'h5E, 0, 0, 8'h00, 1'b0, 0};
    t1 = '{1, 1'b0, 16'hC001, 8'hE5, 0, 0, 8'h00, 1'b0, 0};
    @(posedge b_Clock); #1;
    launch(t0);
    launch(t1);
    tmp = t0; model_fill(tmp); wait_done(0, tmp, 1'b1, 1'b0);
    tmp = t1; model_fill(tmp); wait_done(1, tmp, 1'b1, 1'b0);
    tmp = t0; model_fill(tmp); wait_done(0, tmp, 1'b0, 1'b0);
    req = 2'b00;

    // Directed table; the model runs alongside only to track state
    for (int i = 0; i < 11; i++) begin
      tmp = tbl[i];
      model_fill(tmp);
      @(posedge b_Clock); #1;
      launch(tbl[i]);
      wait_done(tbl[i].c, tbl[i], 1'b0, 1'b0);
    end

    // Randomized singles and pairs against the model
    for (int i = 0; i < 40; i++) begin
      @(posedge b_Clock); #1;
      if ($urandom_range(0, 9) < 3) begin
        rand_txn(0, t0);
        rand_txn(1, t1);
        w  = (m_last == 0) ? 1 : 0;
        tw = (w == 1) ? t1 : t0;
        tl = (w == 1) ? t0 : t1;
        model_fill(tw);
        model_fill(tl);
        launch(t0);
        launch(t1);
        wait_done(w, tw, 1'b0, 1'($urandom_range(0, 1)));
        wait_done(1 - w, tl, 1'b0, 1'b0);
      end else begin
        rand_txn(int'($urandom_range(0, 1)), t);
        model_fill(t);
        launch(t);
        wait_done(t.c, t, 1'b0, 1'($urandom_range(0, 1)));
      end
    end

    // Leave rdata and timed_out non-zero before the mid-operation reset
    t = '{1, 1'b1, 16'hBF11, 8'h00, 0, 4, 8'h00, 1'b0, 0};
    model_fill(t);
    @(posedge b_Clock); #1;
    launch(t);
    wait_done(1, t, 1'b0, 1'b0);
    t = '{0, 1'b1, 16'h3F11, 8'h00, 0, 0, 8'h00, 1'b0, 0};
    model_fill(t);
    @(posedge b_Clock); #1;
    launch(t);
    wait_done(0, t, 1'b0, 1'b0);

    // Reset during RWAIT: outputs clear asynchronously and no done appears
    t = '{0, 1'b1, 16'h3F11, 8'h00, 0, 0, 8'h00, 1'b0, 0};
    @(posedge b_Clock); #1;
    launch(t);
    repeat (8) @(negedge b_Clock);
    check("pre_reset_grant", 32'(grant), 32'h1);
    #2 b_Reset_L = 1'b0;
    #1 check_reset_outputs("midop_reset");
    bad = 0;
    repeat (3) begin
      @(negedge b_Clock);
      if (done !== 2'b00 || grant !== 2'b00) bad = 1;
    end
    check("midop_no_done", 32'(bad), 32'h0);
    req = 2'b00;
    #2 b_Reset_L = 1'b1;
    m_rdata = 8'h00;
    m_last  = 1;

    // After release: the pointer again favours requester 0
    t0 = '{0, 1'b1, 16'h4043, 8'h00, 2, 4, 8'h00, 1'b0, 0};
    t1 = '{1, 1'b0, 16'hC5A0, 8'h3C, 0, 0, 8'h00, 1'b0, 0};
    model_fill(t0);
    model_fill(t1);
    @(posedge b_Clock); #1;
    launch(t0);
    launch(t1);
    wait_done(0, t0, 1'b0, 1'b0);
    wait_done(1, t1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
